// File: rtl/spi_sram_responder_if.sv
// Bus bundle for the SPI SRAM responder: SPI pins, status and host preload port.
interface spi_sram_responder_if;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic        busy;
  logic        cmd_err;
  logic        load_en;
  logic [15:0] load_addr;
  logic [7:0]  load_data;

  // CPU / harness side
  modport master (
    output sclk, cs_n, mosi, load_en, load_addr, load_data,
    input  miso, miso_oe, busy, cmd_err
  );

  // Memory responder side
  modport slave (
    input  sclk, cs_n, mosi, load_en, load_addr, load_data,
    output miso, miso_oe, busy, cmd_err
  );
endinterface

// File: rtl/spi_sram_responder.sv
// SPI mode-0 responder emulating a 23LC-style serial SRAM (READ 03h / WRITE 02h, 16-bit address,
// auto-increment), with SCLK/CS_N/MOSI oversampled on the local clock and a host preload port.
module spi_sram_responder #(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  spi_sram_responder_if.slave bus
);
  localparam int unsigned AddrW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddrH,
    StAddrL,
    StDataRd,
    StDataWr,
    StIgnore
  } state_e;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  state_e      r_state, w_state_next;
  logic [2:0]  r_cnt, w_cnt_next;
  logic [7:0]  r_rx, w_rx_next;
  logic [7:0]  r_tx, w_tx_next;
  logic [15:0] r_addr, w_addr_next;
  logic        r_is_rd, w_is_rd_next;
  logic        r_miso, w_miso_next;
  logic        r_cmd_err, w_cmd_err_next;
  logic        w_spi_we;

  logic [7:0]  r_mem [MEM_DEPTH];

  logic        w_sclk_s, w_cs_s, w_mosi_s;
  logic        w_rise, w_fall, w_cs_fall, w_cs_rise, w_cs_low;
  logic [7:0]  w_shift;
  logic [15:0] w_addr_full;
  logic [15:0] w_addr_inc;
  logic        w_load_we;
  logic        w_unused_load_hi;

  assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    = w_sclk_s & ~r_sclk_d;
  assign w_fall    = ~w_sclk_s & r_sclk_d;
  assign w_cs_fall = ~w_cs_s & r_cs_d;
  assign w_cs_rise = w_cs_s & ~r_cs_d;
  assign w_cs_low  = ~w_cs_s;

  // Byte being completed on this rise (rx shifted with the current mosi bit)
  assign w_shift     = {r_rx[6:0], w_mosi_s};
  assign w_addr_full = {r_addr[15:8], w_shift};
  assign w_addr_inc  = r_addr + 16'd1;

  // busy gating keeps preload and SPI writes from ever landing in the same clk
  assign w_load_we        = bus.load_en & ~w_cs_low;
  assign w_unused_load_hi = ^bus.load_addr[15:AddrW];

  assign bus.busy    = w_cs_low;
  assign bus.miso_oe = w_cs_low && (r_state == StDataRd);
  assign bus.miso    = r_miso && w_cs_low && (r_state == StDataRd);
  assign bus.cmd_err = r_cmd_err;

  // Synchronise SPI pins and keep one delayed copy for edge detection; cs idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= 3'd0;
      r_rx      <= 8'd0;
      r_tx      <= 8'd0;
      r_addr    <= 16'd0;
      r_is_rd   <= 1'b0;
      r_miso    <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_rx      <= w_rx_next;
      r_tx      <= w_tx_next;
      r_addr    <= w_addr_next;
      r_is_rd   <= w_is_rd_next;
      r_miso    <= w_miso_next;
      r_cmd_err <= w_cmd_err_next;
    end
  end

  // Next-state logic: cs edges override everything, then bit/byte handling on sclk edges
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_rx_next      = r_rx;
    w_tx_next      = r_tx;
    w_addr_next    = r_addr;
    w_is_rd_next   = r_is_rd;
    w_miso_next    = r_miso;
    w_cmd_err_next = 1'b0;
    w_spi_we       = 1'b0;

    if (w_cs_rise) begin
      // Abort: any partial byte is dropped without a memory write
      w_state_next = StIdle;
      w_cnt_next   = 3'd0;
      w_miso_next  = 1'b0;
    end else if (w_cs_fall) begin
      w_state_next = StCmd;
      w_cnt_next   = 3'd0;
      w_rx_next    = 8'd0;
      w_miso_next  = 1'b0;
    end else if (w_cs_low) begin
      if (w_fall) begin
        w_miso_next = (r_state == StDataRd) ? r_tx[3'd7 - r_cnt] : 1'b0;
      end
      if (w_rise) begin
        w_rx_next  = w_shift;
        w_cnt_next = r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          unique case (r_state)
            StCmd: begin
              if (w_shift == 8'h03) begin
                w_is_rd_next = 1'b1;
                w_state_next = StAddrH;
              end else if (w_shift == 8'h02) begin
                w_is_rd_next = 1'b0;
                w_state_next = StAddrH;
              end else begin
                w_cmd_err_next = 1'b1;
                w_state_next   = StIgnore;
              end
            end
            StAddrH: begin
              w_addr_next  = {w_shift, r_addr[7:0]};
              w_state_next = StAddrL;
            end
            StAddrL: begin
              w_addr_next = w_addr_full;
              if (r_is_rd) begin
                // First read byte fetched now so bit 7 is ready for the coming fall
                w_tx_next    = r_mem[w_addr_full[AddrW-1:0]];
                w_state_next = StDataRd;
              end else begin
                w_state_next = StDataWr;
              end
            end
            StDataWr: begin
              w_spi_we    = 1'b1;
              w_addr_next = w_addr_inc;
            end
            StDataRd: begin
              w_addr_next = w_addr_inc;
              w_tx_next   = r_mem[w_addr_inc[AddrW-1:0]];
            end
            StIgnore: w_state_next = StIgnore;
            StIdle:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
          endcase
        end
      end
    end
  end

  // Backing store: synchronous write from SPI or preload, never cleared by reset
  always_ff @(posedge clk) begin
    if (w_spi_we) begin
      r_mem[r_addr[AddrW-1:0]] <= w_shift;
    end else if (w_load_we) begin
      r_mem[bus.load_addr[AddrW-1:0]] <= bus.load_data;
    end
  end
endmodule

// File: tb/tb_spi_sram_responder.sv
// Self-checking bench for spi_sram_responder: table-driven SPI frames plus hand-written
// sequences for abort, preload-while-busy and asynchronous reset mid-read.
module tb_spi_sram_responder;
  localparam int HALF = 8;  // clk cycles per sclk phase

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   err_pulses;

  spi_sram_responder_if bus ();

  spi_sram_responder #(
    .MEM_DEPTH  (256),
    .SYNC_STAGES(2)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count clk cycles with cmd_err high; a clean pulse adds exactly one
  always @(posedge clk) begin
    if (bus.cmd_err === 1'b1) err_pulses <= err_pulses + 1;
  end
  initial err_pulses = 0;

  typedef struct {
    logic [7:0]       cmd;
    logic [15:0]      addr;
    int               n;
    logic [3:0][7:0]  dout;  // byte k sent in data phase k
    logic [3:0][7:0]  exp;   // byte k expected on miso
    logic             rd;
    logic             err;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vec [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    bus.load_addr = a;
    bus.load_data = d;
    bus.load_en   = 1'b1;
    @(negedge clk);
    bus.load_en   = 1'b0;
  endtask

  // Shift nbits of tx (MSB first); miso/miso_oe sampled at the end of each low phase
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                          output logic oe_any, output logic oe_all);
    rx     = 8'd0;
    oe_any = 1'b0;
    oe_all = 1'b1;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i]  = bus.miso;
      oe_any = oe_any | bus.miso_oe;
      oe_all = oe_all & bus.miso_oe;
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // Single-byte read frame used by the hand-written sequences
  task automatic read1(input logic [15:0] a, output logic [7:0] rx);
    logic oa, ol;
    logic [7:0] dummy;
    bus.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h03, 8, dummy, oa, ol);
    spi_bits(a[15:8], 8, dummy, oa, ol);
    spi_bits(a[7:0], 8, dummy, oa, ol);
    spi_bits(8'h00, 8, rx, oa, ol);
    cs_end();
  endtask

  initial begin
    logic [7:0] rxb;
    logic       oany, oall, hdr_oe;
    int         e0;

    n_checks = 0;
    n_fail   = 0;

    vec[0] = '{cmd: 8'h03, addr: 16'h0000, n: 4, dout: 32'h0, exp: 32'h44332211, rd: 1, err: 0};
    vec[1] = '{cmd: 8'h02, addr: 16'h0010, n: 2, dout: 32'h00005AA5, exp: 32'h0, rd: 0, err: 0};
    vec[2] = '{cmd: 8'h03, addr: 16'h0010, n: 2, dout: 32'h0, exp: 32'h00005AA5, rd: 1, err: 0};
    vec[3] = '{cmd: 8'h03, addr: 16'h0012, n: 1, dout: 32'h0, exp: 32'h00000077, rd: 1, err: 0};
    vec[4] = '{cmd: 8'h03, addr: 16'h00FF, n: 2, dout: 32'h0, exp: 32'h000011EE, rd: 1, err: 0};
    vec[5] = '{cmd: 8'h9F, addr: 16'h0000, n: 2, dout: 32'hFFFF, exp: 32'h0, rd: 0, err: 1};
    vec[6] = '{cmd: 8'h03, addr: 16'h0000, n: 1, dout: 32'h0, exp: 32'h00000011, rd: 1, err: 0};
    vec[7] = '{cmd: 8'h03, addr: 16'hFF01, n: 1, dout: 32'h0, exp: 32'h00000022, rd: 1, err: 0};

    rst           = 1'b1;
    bus.sclk      = 1'b0;
    bus.cs_n      = 1'b1;
    bus.mosi      = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = 16'h0;
    bus.load_data = 8'h0;
    repeat (4) @(negedge clk);
    check("reset miso", {31'd0, bus.miso}, 0);
    check("reset miso_oe", {31'd0, bus.miso_oe}, 0);
    check("reset busy", {31'd0, bus.busy}, 0);
    check("reset cmd_err", {31'd0, bus.cmd_err}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    preload(16'h0000, 8'h11);
    preload(16'h0001, 8'h22);
    preload(16'h0002, 8'h33);
    preload(16'h0003, 8'h44);
    preload(16'h0012, 8'h77);
    preload(16'h00FF, 8'hEE);
    preload(16'h0020, 8'h3C);
    preload(16'h0030, 8'h5E);
    preload(16'h0040, 8'hFF);

    for (int v = 0; v < NVEC; v++) begin
      e0       = err_pulses;
      bus.cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_bits(vec[v].cmd, 8, rxb, oany, oall);
      hdr_oe = oany;
      spi_bits(vec[v].addr[15:8], 8, rxb, oany, oall);
      hdr_oe = hdr_oe | oany;
      spi_bits(vec[v].addr[7:0], 8, rxb, oany, oall);
      hdr_oe = hdr_oe | oany;
      for (int k = 0; k < vec[v].n; k++) begin
        spi_bits(vec[v].dout[k], 8, rxb, oany, oall);
        check($sformatf("v%0d miso byte%0d", v, k), {24'd0, rxb}, {24'd0, vec[v].exp[k]});
        check($sformatf("v%0d data miso_oe byte%0d", v, k),
              {31'd0, (vec[v].rd ? oall : oany)}, {31'd0, vec[v].rd});
      end
      cs_end();
      check($sformatf("v%0d header miso_oe", v), {31'd0, hdr_oe}, 0);
      check($sformatf("v%0d cmd_err pulses", v), err_pulses - e0, {31'd0, vec[v].err});
      check($sformatf("v%0d busy after frame", v), {31'd0, bus.busy}, 0);
    end

    // Write to 0x20 aborted after 5 data bits
    bus.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h02, 8, rxb, oany, oall);
    spi_bits(8'h00, 8, rxb, oany, oall);
    spi_bits(8'h20, 8, rxb, oany, oall);
    spi_bits(8'hA0, 5, rxb, oany, oall);
    cs_end();
    check("abort busy", {31'd0, bus.busy}, 0);
    check("abort miso_oe", {31'd0, bus.miso_oe}, 0);
    read1(16'h0020, rxb);
    check("abort mem[20]", {24'd0, rxb}, 32'h3C);

    // Preload while busy is ignored; after cs_n high it lands
    bus.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    check("preload busy seen", {31'd0, bus.busy}, 1);
    preload(16'h0030, 8'h99);
    cs_end();
    read1(16'h0030, rxb);
    check("busy preload ignored", {24'd0, rxb}, 32'h5E);
    preload(16'h0030, 8'h99);
    read1(16'h0030, rxb);
    check("idle preload written", {24'd0, rxb}, 32'h99);

    // Asynchronous reset in the middle of a read data byte
    bus.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h03, 8, rxb, oany, oall);
    spi_bits(8'h00, 8, rxb, oany, oall);
    spi_bits(8'h40, 8, rxb, oany, oall);
    spi_bits(8'h00, 2, rxb, oany, oall);
    repeat (HALF) @(negedge clk);
    check("pre-reset miso", {31'd0, bus.miso}, 1);
    check("pre-reset miso_oe", {31'd0, bus.miso_oe}, 1);
    #3 rst = 1'b1;
    #1;
    check("async rst miso", {31'd0, bus.miso}, 0);
    check("async rst miso_oe", {31'd0, bus.miso_oe}, 0);
    check("async rst busy", {31'd0, bus.busy}, 0);
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    read1(16'h0000, rxb);
    check("post-reset read mem[0]", {24'd0, rxb}, 32'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
